add_tree128: RTL and testbench

//  Pipelined, signed 128-input adder tree reducing 128 x 19-bit operands to one 19-bit sum.
//  It is the accumulation core of the BNN neurons: neuron_l1/neuron_l2 feed it partial

---
 rtl/add_tree_pkg.sv | 38 +++
 rtl/add_tree128_if.sv | 11 +
 rtl/add_tree_level.sv | 32 +++
 rtl/add_tree128.sv | 39 +++
 tb/tb_add_tree128.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/add_tree_pkg.sv
// rtl/add_tree_pkg.sv - shared constants and saturation helper for the 128-input adder tree
package add_tree_pkg;

    localparam int N_IN   = 128;
    localparam int IN_W   = 19;
    localparam int OUT_W  = 19;
    localparam int LEVELS = $clog2(N_IN);
    localparam int SUM_W  = IN_W + LEVELS;

    // Bit offset of level k inside a flat vector holding levels 0..k-1 back to back.
    function automatic int lvl_offset(input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off += (N_IN >> j) * (IN_W + j);
        end
        return off;
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_signed(
        input logic signed [SUM_W-1:0] value,
        input int                      out_w
    );
        logic signed [SUM_W-1:0] one;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        one = 1;
        hi  = (one <<< (out_w - 1)) - one;
        lo  = ~hi;
        if (value > hi) begin
            return hi[OUT_W-1:0];
        end else if (value < lo) begin
            return lo[OUT_W-1:0];
        end
        return value[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/add_tree128_if.sv
// rtl/add_tree128_if.sv - operand bus and saturated sum of the adder tree
interface add_tree128_if;
    import add_tree_pkg::*;

    logic [N_IN-1:0][IN_W-1:0] in;
    logic [OUT_W-1:0]          out;

    modport master (output in, input out);
    modport slave  (input in, output out);

endinterface

// File: rtl/add_tree_level.sv
// rtl/add_tree_level.sv - one registered pairwise-add level, output one bit wider than input
module add_tree_level #(
    parameter int N = 2,
    parameter int W = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0][W-1:0]   in_i,
    output logic [N/2-1:0][W:0]   sum_o
);

    logic [N/2-1:0][W:0] sum_d;
    logic [N/2-1:0][W:0] sum_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N / 2; i++) begin
            sum_d[i] = {in_i[2*i+1][W-1], in_i[2*i+1]} + {in_i[2*i][W-1], in_i[2*i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/add_tree128.sv
// rtl/add_tree128.sv - pipelined signed 128-input adder tree, one level per clock, saturating output
module add_tree128
    import add_tree_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    add_tree128_if.slave  bus
);

    localparam int TOTAL_W = lvl_offset(LEVELS + 1);

    // Every level packed back to back; level 0 is the raw operand bus.
    wire [TOTAL_W-1:0] flat;

    assign flat[0 +: N_IN*IN_W] = bus.in;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_PREV   = N_IN >> (k - 1);
        localparam int W_PREV   = IN_W + k - 1;
        localparam int OFF_PREV = lvl_offset(k - 1);
        localparam int OFF_CUR  = lvl_offset(k);

        add_tree_level #(
            .N (N_PREV),
            .W (W_PREV)
        ) u_level (
            .clk   (clk),
            .rst   (rst),
            .in_i  (flat[OFF_PREV +: N_PREV*W_PREV]),
            .sum_o (flat[OFF_CUR +: (N_PREV/2)*(W_PREV+1)])
        );
    end

    logic signed [SUM_W-1:0] sum_final;

    assign sum_final = flat[lvl_offset(LEVELS) +: SUM_W];
    assign bus.out   = sat_signed(sum_final, OUT_W);

endmodule

// File: tb/tb_add_tree128.sv
// tb/tb_add_tree128.sv - directed and streaming checks of add_tree128 against a bench-side sum model
module tb_add_tree128;
    import add_tree_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [N_IN-1:0][IN_W-1:0] vec;
    int   expq[$];

    add_tree128_if bus ();

    add_tree128 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_val();
        logic signed [OUT_W-1:0] o;
        o = bus.out;
        return int'(o);
    endfunction

    function automatic int sat_ref(input longint s);
        if (s > 262143)  return 262143;
        if (s < -262144) return -262144;
        return int'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N_IN; i++) vec[i] = IN_W'(v);
        bus.in = vec;
    endtask

    task automatic hold_check(input string tag, input int exp);
        for (int e = 0; e < LEVELS; e++) step();
        check(tag, out_val(), exp);
    endtask

    // Random vector; small-range or full-range operands, reference sum returned.
    task automatic rand_vec(output int exp);
        longint s;
        int     x;
        bit     full;
        s    = 0;
        full = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < N_IN; i++) begin
            if (full) x = int'($urandom_range(0, 524287)) - 262144;
            else      x = int'($urandom_range(0, 4000)) - 2000;
            vec[i] = IN_W'(x);
            s += x;
        end
        bus.in = vec;
        exp = sat_ref(s);
    endtask

    initial begin
        int e_tmp;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        fill(0);
        #1;
        step();
        step();
        check("reset_out", out_val(), 0);

        rst = 1'b0;
        fill(1);
        for (int e = 1; e <= LEVELS + 2; e++) begin
            step();
            check("ones_latency", out_val(), (e < LEVELS) ? 0 : 128);
        end

        rst = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            check("ones_in_reset", out_val(), 0);
        end
        rst = 1'b0;
        for (int e = 1; e <= LEVELS; e++) begin
            step();
            check("ones_after_release", out_val(), (e < LEVELS) ? 0 : 128);
        end

        fill(262143);
        hold_check("sat_pos", 262143);
        fill(-262144);
        hold_check("sat_neg", -262144);

        for (int i = 0; i < N_IN; i++) vec[i] = IN_W'(i - 64);
        bus.in = vec;
        hold_check("ramp", -64);

        for (int i = 0; i < N_IN; i++) vec[i] = IN_W'((i % 2 == 0) ? 1000 : -1000);
        bus.in = vec;
        hold_check("alternating", 0);

        fill(0);
        vec[0] = IN_W'(262143);
        bus.in = vec;
        hold_check("max_exact", 262143);
        vec[1] = IN_W'(1);
        bus.in = vec;
        hold_check("max_plus_one", 262143);
        fill(0);
        vec[5] = IN_W'(-262144);
        bus.in = vec;
        hold_check("min_exact", -262144);
        vec[77] = IN_W'(-1);
        bus.in = vec;
        hold_check("min_minus_one", -262144);
        fill(0);
        vec[127] = IN_W'(-3);
        vec[64]  = IN_W'(7);
        bus.in = vec;
        hold_check("sparse", 4);

        expq.delete();
        for (int t = 0; t < 200 + LEVELS - 1; t++) begin
            if (t < 200) begin
                rand_vec(e_tmp);
                expq.push_back(e_tmp);
            end
            step();
            if (t >= LEVELS - 1) check("stream", out_val(), expq[t-(LEVELS-1)]);
        end

        for (int t = 0; t < 10; t++) begin
            rand_vec(e_tmp);
            step();
        end
        rst = 1'b1;
        rand_vec(e_tmp);
        step();
        check("midstream_reset", out_val(), 0);
        rst = 1'b0;
        expq.delete();
        for (int t = 0; t < 12; t++) begin
            rand_vec(e_tmp);
            expq.push_back(e_tmp);
            step();
            if (t < LEVELS - 1) check("post_reset_zero", out_val(), 0);
            else                check("post_reset_stream", out_val(), expq[t-(LEVELS-1)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
